// File: rtl/ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ram_fifo_ctrl
//   Synchronous FIFO controller placed directly in front of a single-port RAM.
//   It turns push/pop requests into at most one registered RAM access per
//   cycle, tracks read/write pointers and occupancy, and registers the RAM
//   read data back out to the consumer.
//
//   Pop has priority over push. When a pop is accepted in the same cycle as a
//   push request, the push is refused (push_ready=0).
//
//   Pop-to-data latency is 2 cycles:
//     accept edge -> RD cycle on the RAM bus -> capture edge (pop_valid=1).
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   push          producer write request
//   push_data     word to enqueue
//   push_ready    push accepted this cycle if push=1 (combinational)
//   pop           consumer read request
//   pop_data      dequeued word, valid while pop_valid=1, held until next read
//   pop_valid     one-cycle strobe per accepted pop
//   full, empty   occupancy flags
//   count         current occupancy (0..memory_size)
//   ram_addr      to RAM addr
//   ram_data_in   to RAM data_in
//   ram_data_out  from RAM data_out (combinational read)
//   ram_wr        to RAM wr
//   ram_cs        to RAM cs
//   ovf, udf      sticky overflow/underflow flags (RAM_FIFO_ERR_EN only)
//
// Configuration
//   RAM_FIFO_ERR_EN : when defined, adds the sticky ovf/udf outputs.
// ---------------------------------------------------------------------------
module ram_fifo_ctrl #(
    parameter int addr_size   = 10,
    parameter int word_size   = 8,
    parameter int memory_size = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [word_size-1:0] push_data,
    output logic                 push_ready,
    input  logic                 pop,
    output logic [word_size-1:0] pop_data,
    output logic                 pop_valid,
    output logic                 full,
    output logic                 empty,
    output logic [addr_size:0]   count,
    output logic [addr_size-1:0] ram_addr,
    output logic [word_size-1:0] ram_data_in,
    input  logic [word_size-1:0] ram_data_out,
    output logic                 ram_wr,
`ifdef RAM_FIFO_ERR_EN
    output logic                 ovf,
    output logic                 udf,
`endif
    output logic                 ram_cs
);

    // State names the access driven on the RAM bus during the current cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    localparam logic [addr_size:0]   DEPTH   = (addr_size+1)'(memory_size);
    localparam logic [addr_size-1:0] PTR_ONE = {{(addr_size-1){1'b0}}, 1'b1};
    localparam logic [addr_size:0]   CNT_ONE = {{addr_size{1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [addr_size-1:0]   wr_ptr_q, wr_ptr_d;
    logic [addr_size-1:0]   rd_ptr_q, rd_ptr_d;
    logic [addr_size:0]     count_q, count_d;
    logic [addr_size-1:0]   ram_addr_q, ram_addr_d;
    logic [word_size-1:0]   ram_data_in_q, ram_data_in_d;
    logic [word_size-1:0]   pop_data_q, pop_data_d;
    logic                   pop_valid_q, pop_valid_d;

    logic pop_acc;
    logic push_acc;

    assign full  = (count_q == DEPTH);
    assign empty = (count_q == '0);

    assign pop_acc    = pop & ~empty;
    assign push_acc   = push & ~full & ~pop_acc;
    assign push_ready = ~full & ~pop_acc;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d       = IDLE;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        ram_addr_d    = ram_addr_q;
        ram_data_in_d = ram_data_in_q;
        pop_data_d    = pop_data_q;
        pop_valid_d   = 1'b0;

        if (pop_acc) begin
            state_d    = RD;
            ram_addr_d = rd_ptr_q;
            rd_ptr_d   = rd_ptr_q + PTR_ONE;   // wraps naturally at 2**addr_size
            count_d    = count_q - CNT_ONE;
        end else if (push_acc) begin
            state_d       = WR;
            ram_addr_d    = wr_ptr_q;
            ram_data_in_d = push_data;
            wr_ptr_d      = wr_ptr_q + PTR_ONE;
            count_d       = count_q + CNT_ONE;
        end

        // The RAM read is combinational, so the word addressed during an RD
        // cycle is present on ram_data_out at the edge that ends it.
        if (state_q == RD) begin
            pop_data_d  = ram_data_out;
            pop_valid_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ram_addr_q    <= '0;
            ram_data_in_q <= '0;
            pop_data_q    <= '0;
            pop_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_in_q <= ram_data_in_d;
            pop_data_q    <= pop_data_d;
            pop_valid_q   <= pop_valid_d;
        end
    end

    assign ram_cs      = (state_q != IDLE);
    assign ram_wr      = (state_q == WR);
    assign ram_addr    = ram_addr_q;
    assign ram_data_in = ram_data_in_q;
    assign pop_data    = pop_data_q;
    assign pop_valid   = pop_valid_q;
    assign count       = count_q;

`ifdef RAM_FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // Sticky: set on any illegal request, cleared only by reset.
    always_comb begin
        ovf_d = ovf_q | (push & full);
        udf_d = udf_q | (pop & empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_fifo_ctrl
//   Self-checking bench for ram_fifo_ctrl. A behavioural single-port RAM is
//   attached to the RAM pins. A reference model tracks occupancy and queues
//   every accepted push word; a monitor compares each pop_valid word against
//   the queue front and compares count/full/empty against the model on every
//   falling edge. Inputs change 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_ram_fifo_ctrl;

    localparam int AW    = 10;
    localparam int WW    = 8;
    localparam int DEPTH = 1024;

    logic          clk;
    logic          rst;
    logic          push;
    logic [WW-1:0] push_data;
    logic          push_ready;
    logic          pop;
    logic [WW-1:0] pop_data;
    logic          pop_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic [AW-1:0] ram_addr;
    logic [WW-1:0] ram_data_in;
    logic [WW-1:0] ram_data_out;
    logic          ram_wr;
    logic          ram_cs;
`ifdef RAM_FIFO_ERR_EN
    logic          ovf;
    logic          udf;
`endif

    int checks   = 0;
    int failures = 0;

    ram_fifo_ctrl #(
        .addr_size  (AW),
        .word_size  (WW),
        .memory_size(DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_data   (push_data),
        .push_ready  (push_ready),
        .pop         (pop),
        .pop_data    (pop_data),
        .pop_valid   (pop_valid),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .ram_addr    (ram_addr),
        .ram_data_in (ram_data_in),
        .ram_data_out(ram_data_out),
        .ram_wr      (ram_wr),
`ifdef RAM_FIFO_ERR_EN
        .ovf         (ovf),
        .udf         (udf),
`endif
        .ram_cs      (ram_cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM: synchronous write, combinational read.
    logic [WW-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end
    always @(posedge clk) begin
        if (ram_cs && ram_wr) mem[ram_addr] <= ram_data_in;
    end
    assign ram_data_out = mem[ram_addr];

    // Reference model: acceptance rules and occupancy, scoreboard of words.
    int            m_count = 0;
    logic [WW-1:0] exp_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_count = 0;
            exp_q.delete();
        end else begin
            automatic bit pa = pop && (m_count != 0);
            automatic bit ha = push && (m_count != DEPTH) && !pa;
            if (ha) begin
                exp_q.push_back(push_data);
                m_count++;
            end
            if (pa) m_count--;
        end
    end

    // Monitor: data order and occupancy, sampled on the falling edge.
    always @(negedge clk) begin
        checks++;
        if (pop_valid) begin
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_valid_unexpected: got pop_data=%h, scoreboard empty", pop_data);
            end else begin
                automatic logic [WW-1:0] e = exp_q.pop_front();
                if (pop_data !== e) begin
                    failures++;
                    $display("FAIL pop_data_order: got %h expected %h", pop_data, e);
                end
            end
        end
        checks++;
        if (count !== m_count[AW:0] || full !== (m_count == DEPTH) || empty !== (m_count == 0)) begin
            failures++;
            $display("FAIL occupancy: count=%0d full=%b empty=%b expected count=%0d", count, full, empty, m_count);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
        #3;
        checks++;
        if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || ram_cs !== 1'b0 || ram_wr !== 1'b0 ||
            ram_addr !== '0 || ram_data_in !== '0 || pop_data !== '0 || pop_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b cs=%b wr=%b addr=%0d din=%h pd=%h pv=%b",
                     count, empty, full, ram_cs, ram_wr, ram_addr, ram_data_in, pop_data, pop_valid);
        end
        checks++;
        if (push_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_push_ready: got %b expected 1", push_ready);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_pop_empty();
        pop = 1'b1;
        #1;
        checks++;
        if (push_ready !== 1'b1) begin
            failures++;
            $display("FAIL pop_empty_push_ready: got %b expected 1", push_ready);
        end
        step();
        pop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ram_cs !== 1'b0 || pop_valid !== 1'b0) begin
                failures++;
                $display("FAIL pop_empty_no_access: cs=%b pop_valid=%b expected 0 0", ram_cs, pop_valid);
            end
            step();
        end
`ifdef RAM_FIFO_ERR_EN
        checks++;
        if (udf !== 1'b1 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL udf_sticky: udf=%b ovf=%b expected 1 0", udf, ovf);
        end
`endif
    endtask

    task automatic test_push_pop();
        push = 1'b1; push_data = 8'hA5;
        step();
        push = 1'b0;
        checks++;
        if (ram_cs !== 1'b1 || ram_wr !== 1'b1 || ram_addr !== 10'd0 || ram_data_in !== 8'hA5) begin
            failures++;
            $display("FAIL push_wr_cycle: cs=%b wr=%b addr=%0d din=%h expected 1 1 0 a5",
                     ram_cs, ram_wr, ram_addr, ram_data_in);
        end
        pop = 1'b1;
        step();
        pop = 1'b0;
        checks++;
        if (ram_cs !== 1'b1 || ram_wr !== 1'b0 || ram_addr !== 10'd0) begin
            failures++;
            $display("FAIL pop_rd_cycle: cs=%b wr=%b addr=%0d expected 1 0 0", ram_cs, ram_wr, ram_addr);
        end
        step();
        checks++;
        if (pop_valid !== 1'b1 || pop_data !== 8'hA5 || ram_cs !== 1'b0) begin
            failures++;
            $display("FAIL pop_latency: pop_valid=%b pop_data=%h cs=%b expected 1 a5 0", pop_valid, pop_data, ram_cs);
        end
        step();
        checks++;
        if (pop_valid !== 1'b0 || pop_data !== 8'hA5) begin
            failures++;
            $display("FAIL pop_hold: pop_valid=%b pop_data=%h expected 0 a5", pop_valid, pop_data);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; push_data = 8'h30 + WW'(i);
            step();
        end
        push = 1'b1; pop = 1'b1; push_data = 8'hEE;
        #1;
        checks++;
        if (push_ready !== 1'b0) begin
            failures++;
            $display("FAIL simul_push_ready: got %b expected 0", push_ready);
        end
        step();
        push = 1'b0; pop = 1'b0;
        checks++;
        if (count !== 11'd2 || ram_wr !== 1'b0 || ram_addr !== 10'd1) begin
            failures++;
            $display("FAIL simul_pop_served: count=%0d wr=%b addr=%0d expected 2 0 1", count, ram_wr, ram_addr);
        end
        pop = 1'b1;
        step(); step();
        pop = 1'b0;
        step(); step();
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            push = 1'b1; push_data = WW'(i);
            step();
        end
        #1;
        checks++;
        if (full !== 1'b1 || count !== 11'd1024 || push_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: full=%b count=%0d push_ready=%b expected 1 1024 0", full, count, push_ready);
        end
        push_data = 8'h77;
        step();
        push = 1'b0;
        checks++;
        if (count !== 11'd1024 || ram_cs !== 1'b0) begin
            failures++;
            $display("FAIL overflow_ignored: count=%0d cs=%b expected 1024 0", count, ram_cs);
        end
`ifdef RAM_FIFO_ERR_EN
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky: got %b expected 1", ovf);
        end
`endif
        pop = 1'b1;
        for (int i = 0; i < DEPTH; i++) step();
        pop = 1'b0;
        step(); step(); step();
        checks++;
        if (empty !== 1'b1 || count !== '0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL fill_drain: empty=%b count=%0d left=%0d expected 1 0 0", empty, count, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_write();
        push = 1'b1; push_data = 8'h5A;
        step();
        push = 1'b0;
        checks++;
        if (ram_cs !== 1'b1 || ram_wr !== 1'b1) begin
            failures++;
            $display("FAIL mid_write_setup: cs=%b wr=%b expected 1 1", ram_cs, ram_wr);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ram_cs !== 1'b0 || count !== '0 || empty !== 1'b1 || pop_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_write: cs=%b count=%0d empty=%b pop_valid=%b expected 0 0 1 0",
                     ram_cs, count, empty, pop_valid);
        end
`ifdef RAM_FIFO_ERR_EN
        checks++;
        if (ovf !== 1'b0 || udf !== 1'b0) begin
            failures++;
            $display("FAIL err_cleared: ovf=%b udf=%b expected 0 0", ovf, udf);
        end
`endif
        #2 rst = 1'b0;
        step();
        checks++;
        if (ram_cs !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_idle: cs=%b empty=%b expected 0 1", ram_cs, empty);
        end
    endtask

    task automatic test_stream();
        int pushed = 0;
        int cycles = 0;
        while (pushed < 1500 && cycles < 20000) begin
            push      = 1'b1;
            push_data = WW'(pushed * 7 + 3);
            pop       = ($urandom_range(0, 2) == 0);
            #1;
            if (push_ready) pushed++;
            step();
            cycles++;
        end
        push = 1'b0;
        checks++;
        if (pushed != 1500) begin
            failures++;
            $display("FAIL stream_budget: pushed=%0d expected 1500", pushed);
        end
        pop = 1'b1;
        cycles = 0;
        while (m_count != 0 && cycles < 3000) begin
            step();
            cycles++;
        end
        pop = 1'b0;
        step(); step(); step();
        checks++;
        if (empty !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL stream_drain: empty=%b left=%0d expected 1 0", empty, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_pop_empty();
        test_push_pop();
        test_simultaneous();
        test_fill();
        test_reset_mid_write();
        test_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
